wb_rr_arbiter: RTL and testbench

Round-robin Wishbone B4 arbiter that shares the single slave (`wishbone_top` slave port) between `NUM_M` masters. It holds the grant for the whole `cyc` tenure, including CTI bursts. A per-transfer watchdog converts a hung slave into a master-side `err`. The arbiter sits between the master ports and the slave's `cyc/stb/addr/data/we/sel/cti/tag_add` inputs.

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_arb_rr_pick.sv | 32 +++
 rtl/wb_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  // Arbiter FSM encoding; the top exposes this value directly on state_out.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    ABORT = 2'b10
  } arb_state_e;

  // Wishbone B4 cycle type identifiers seen on the cti lines.
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Watchdog counter width; covers the full 2..255 timeout range.
  localparam int WD_W = 8;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: searches from last_gnt+1 upward,
// wrapping, and returns the first requester as a one-hot grant.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [NUM_M-1:0] gnt
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the ring starting just after the previous winner; the first
  // requester met wins, so the previous winner is considered last.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = last_gnt;
    for (int k = 0; k < NUM_M; k++) begin
      cand = (cand == IDX_W'(NUM_M - 1)) ? '0 : cand + IDX_W'(1);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter sharing one slave between NUM_M masters.
// The grant is held for the whole cyc tenure; a per-transfer watchdog turns
// a hung slave into a single err pulse to the owning master.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_M      = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_M-1:0]            m_cyc_i,
  input  logic [NUM_M-1:0]            m_stb_i,
  input  logic [NUM_M-1:0]            m_we_i,
  input  logic [NUM_M-1:0]            m_tag_i,
  input  logic [NUM_M*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_M*DATA_WIDTH-1:0] m_data_i,
  input  logic [NUM_M*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_M*3-1:0]          m_cti_i,
  output logic [NUM_M-1:0]            m_ack_o,
  output logic [NUM_M-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]       m_data_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic                        s_tag_o,
  output logic [ADDR_WIDTH-1:0]       s_addr_o,
  output logic [DATA_WIDTH-1:0]       s_data_o,
  output logic [SEL_WIDTH-1:0]        s_sel_o,
  output logic [2:0]                  s_cti_o,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic [DATA_WIDTH-1:0]       s_data_i,
  output logic [NUM_M-1:0]            gnt_o,
  output logic [1:0]                  state_out,
  output logic                        timeout_o
);

  localparam int             IDX_W   = $clog2(NUM_M);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_e       state_reg;
  logic [NUM_M-1:0] gnt_reg;
  logic [IDX_W-1:0] last_gnt_reg;
  logic [WD_W-1:0]  wd_cnt_reg;
  logic             timeout_reg;

  logic [NUM_M-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] idx_chain [NUM_M+1];

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_M];
  logic [DATA_WIDTH-1:0] data_arr [NUM_M];
  logic [SEL_WIDTH-1:0]  sel_arr  [NUM_M];
  logic [2:0]            cti_arr  [NUM_M];

  logic is_busy;
  logic is_abort;

  // Split the flat per-master buses and turn the picker's one-hot result
  // into an index by OR-ing each granted position into a chain.
  assign idx_chain[0] = '0;
  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
      assign addr_arr[gi]    = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi]    = m_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sel_arr[gi]     = m_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
      assign cti_arr[gi]     = m_cti_i[gi*3 +: 3];
      assign idx_chain[gi+1] = idx_chain[gi] | (pick_gnt[gi] ? IDX_W'(gi) : '0);

      // Responses reach only the owning master; the timeout err is shown
      // for the first ABORT cycle only.
      assign m_ack_o[gi] = is_busy & gnt_reg[gi] & s_ack_i;
      assign m_err_o[gi] = gnt_reg[gi] & ((is_busy & s_err_i) | (is_abort & timeout_reg));
    end
  endgenerate
  assign pick_idx = idx_chain[NUM_M];

  wb_arb_rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (m_cyc_i),
    .last_gnt (last_gnt_reg),
    .gnt      (pick_gnt)
  );

  assign is_busy  = (state_reg == BUSY);
  assign is_abort = (state_reg == ABORT);

  // Slave side mux. last_gnt_reg always holds the current owner's index
  // while BUSY, so it doubles as the mux select. Outside BUSY the slave
  // sees an idle, all-zero bus.
  assign s_cyc_o  = is_busy & m_cyc_i[last_gnt_reg];
  assign s_stb_o  = is_busy & m_stb_i[last_gnt_reg];
  assign s_we_o   = is_busy & m_we_i[last_gnt_reg];
  assign s_tag_o  = is_busy & m_tag_i[last_gnt_reg];
  assign s_addr_o = is_busy ? addr_arr[last_gnt_reg] : '0;
  assign s_data_o = is_busy ? data_arr[last_gnt_reg] : '0;
  assign s_sel_o  = is_busy ? sel_arr[last_gnt_reg]  : '0;
  assign s_cti_o  = is_busy ? cti_arr[last_gnt_reg]  : '0;
  assign m_data_o = is_busy ? s_data_i : '0;

  assign gnt_o     = gnt_reg;
  assign state_out = state_reg;
  assign timeout_o = timeout_reg;

  // Arbitration FSM and watchdog: grant in IDLE, hold for the cyc tenure in
  // BUSY, and park in ABORT after a timeout until the owner drops cyc.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      last_gnt_reg <= IDX_W'(NUM_M - 1);
      wd_cnt_reg   <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          wd_cnt_reg <= '0;
          if (|pick_gnt) begin
            gnt_reg      <= pick_gnt;
            last_gnt_reg <= pick_idx;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (!m_cyc_i[last_gnt_reg]) begin
            gnt_reg    <= '0;
            wd_cnt_reg <= '0;
            state_reg  <= IDLE;
          end else if (s_stb_o && !s_ack_i && !s_err_i) begin
            if (wd_cnt_reg == WD_LAST) begin
              wd_cnt_reg  <= '0;
              timeout_reg <= 1'b1;
              state_reg   <= ABORT;
            end else begin
              wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end
          end else begin
            wd_cnt_reg <= '0;
          end
        end
        ABORT: begin
          wd_cnt_reg <= '0;
          if (!m_cyc_i[last_gnt_reg]) begin
            gnt_reg   <= '0;
            state_reg <= IDLE;
          end
        end
        default: begin
          gnt_reg    <= '0;
          wd_cnt_reg <= '0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: masters and slave are driven from
// tasks; expected slave-side transfers go into a scoreboard queue when a
// master issues them and are popped when the slave acknowledges.
module tb_wb_rr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int NM = 2;
  localparam int TO = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
    logic          mi;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;

  logic          c_cyc  [NM];
  logic          c_stb  [NM];
  logic          c_we   [NM];
  logic          c_tag  [NM];
  logic [AW-1:0] c_addr [NM];
  logic [DW-1:0] c_data [NM];
  logic [SW-1:0] c_sel  [NM];
  logic [2:0]    c_cti  [NM];

  logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i, m_tag_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_data_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic [DW-1:0]    m_data_o;
  logic             s_cyc_o, s_stb_o, s_we_o, s_tag_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_data_o;
  logic [SW-1:0]    s_sel_o;
  logic [2:0]       s_cti_o;
  logic             s_ack_i = 1'b0;
  logic             s_err_i = 1'b0;
  logic [DW-1:0]    s_data_i = '0;
  logic [NM-1:0]    gnt_o;
  logic [1:0]       state_out;
  logic             timeout_o;

  assign m_cyc_i  = {c_cyc[1], c_cyc[0]};
  assign m_stb_i  = {c_stb[1], c_stb[0]};
  assign m_we_i   = {c_we[1], c_we[0]};
  assign m_tag_i  = {c_tag[1], c_tag[0]};
  assign m_addr_i = {c_addr[1], c_addr[0]};
  assign m_data_i = {c_data[1], c_data[0]};
  assign m_sel_i  = {c_sel[1], c_sel[0]};
  assign m_cti_i  = {c_cti[1], c_cti[0]};

  always #5 clk_i = ~clk_i;

  wb_rr_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SEL_WIDTH  (SW),
    .NUM_M      (NM),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_tag_i   (m_tag_i),
    .m_addr_i  (m_addr_i),
    .m_data_i  (m_data_i),
    .m_sel_i   (m_sel_i),
    .m_cti_i   (m_cti_i),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_data_o  (m_data_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_tag_o   (s_tag_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_sel_o   (s_sel_o),
    .s_cti_o   (s_cti_o),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_data_i  (s_data_i),
    .gnt_o     (gnt_o),
    .state_out (state_out),
    .timeout_o (timeout_o)
  );

  function automatic logic [NM-1:0] oh(input logic mi);
    return mi ? 2'b10 : 2'b01;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 2-3 time units
  // after the rising edge, well away from it.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv(input logic mi, input logic cyc, input logic stb, input logic we,
                     input logic [AW-1:0] addr, input logic [DW-1:0] data,
                     input logic [2:0] cti);
    c_cyc[mi]  = cyc;
    c_stb[mi]  = stb;
    c_we[mi]   = we;
    c_tag[mi]  = mi;
    c_addr[mi] = addr;
    c_data[mi] = data;
    c_sel[mi]  = '1;
    c_cti[mi]  = cti;
  endtask

  task automatic push(input logic mi, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.we   = we;
    e.mi   = mi;
    sb_q.push_back(e);
  endtask

  task automatic idle_all();
    drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    drv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    s_ack_i  = 1'b0;
    s_err_i  = 1'b0;
    s_data_i = '0;
  endtask

  task automatic apply_reset();
    idle_all();
    sb_q.delete();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    settle();
  endtask

  // Slave acknowledges the transfer currently on its port: pop the expected
  // transfer and compare the slave-side view, then assert ack and compare
  // the master-side response.
  task automatic slave_ack(input logic [DW-1:0] rdata);
    exp_t e;
    e = '0;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got no expected transfer, required one queued");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (s_addr_o !== e.addr) begin
        n_fail++;
        $display("FAIL sb_addr: got %h required %h", s_addr_o, e.addr);
      end
      n_checks++;
      if (s_we_o !== e.we) begin
        n_fail++;
        $display("FAIL sb_we: got %b required %b", s_we_o, e.we);
      end
      n_checks++;
      if (e.we && (s_data_o !== e.data)) begin
        n_fail++;
        $display("FAIL sb_wdata: got %h required %h", s_data_o, e.data);
      end
      n_checks++;
      if ({s_cyc_o, s_stb_o, gnt_o} !== {2'b11, oh(e.mi)}) begin
        n_fail++;
        $display("FAIL sb_owner: got cyc/stb/gnt %b required %b", {s_cyc_o, s_stb_o, gnt_o},
                 {2'b11, oh(e.mi)});
      end
    end
    s_ack_i  = 1'b1;
    s_data_i = rdata;
    settle();
    n_checks++;
    if (m_ack_o !== oh(e.mi)) begin
      n_fail++;
      $display("FAIL sb_ack: got %b required %b", m_ack_o, oh(e.mi));
    end
    n_checks++;
    if (!e.we && (m_data_o !== rdata)) begin
      n_fail++;
      $display("FAIL sb_rdata: got %h required %h", m_data_o, rdata);
    end
    $display("txn m%0d addr=%h we=%b wdata=%h ack=%b", e.mi, s_addr_o, s_we_o, s_data_o, m_ack_o);
  endtask

  task automatic test_reset();
    idle_all();
    #3;
    rst_ni = 1'b0;
    settle();
    n_checks++;
    if ({state_out, gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0",
               {state_out, gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o});
    end
    tick();
    rst_ni = 1'b1;
    tick();
    settle();
    n_checks++;
    if ({state_out, gnt_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: got state/gnt %b required 0000", {state_out, gnt_o});
    end
  endtask

  task automatic test_single();
    drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h0000_1111, 3'b000);
    push(1'b0, 1'b1, 5'd0, 32'h0000_1111);
    settle();
    n_checks++;
    if ({gnt_o, s_cyc_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_latency: got gnt/cyc %b required 000", {gnt_o, s_cyc_o});
    end
    tick();
    n_checks++;
    if ({state_out, gnt_o, s_cyc_o, s_sel_o} !== {2'b01, 2'b01, 1'b1, 4'hF}) begin
      n_fail++;
      $display("FAIL single_grant: got %b required %b", {state_out, gnt_o, s_cyc_o, s_sel_o},
               {2'b01, 2'b01, 1'b1, 4'hF});
    end
    tick();
    slave_ack(32'h0);
    tick();
    s_ack_i = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    settle();
    n_checks++;
    if (m_ack_o !== 2'b00) begin
      n_fail++;
      $display("FAIL single_ack_pulse: got %b required 00", m_ack_o);
    end
    tick();
    n_checks++;
    if ({state_out, gnt_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_release: got state/gnt %b required 0000", {state_out, gnt_o});
    end
  endtask

  task automatic test_contention();
    apply_reset();
    drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'hAAAA_0001, 3'b000);
    drv(1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 32'hBBBB_0002, 3'b000);
    push(1'b0, 1'b1, 5'd1, 32'hAAAA_0001);
    push(1'b1, 1'b1, 5'd2, 32'hBBBB_0002);
    tick();
    n_checks++;
    if (gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL cont_first: got %b required 01", gnt_o);
    end
    tick();
    slave_ack(32'h0);
    tick();
    s_ack_i = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    tick();
    n_checks++;
    if ({state_out, gnt_o, s_cyc_o} !== 5'b00000) begin
      n_fail++;
      $display("FAIL cont_dead_cycle: got state/gnt/cyc %b required 00000",
               {state_out, gnt_o, s_cyc_o});
    end
    tick();
    n_checks++;
    if (gnt_o !== 2'b10) begin
      n_fail++;
      $display("FAIL cont_second: got %b required 10", gnt_o);
    end
    tick();
    slave_ack(32'h0);
    tick();
    s_ack_i = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    tick();
  endtask

  task automatic test_burst();
    logic [2:0] cti;
    drv(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0104, 3'b010);
    push(1'b1, 1'b1, 5'd4, 32'h0000_0104);
    tick();
    n_checks++;
    if (gnt_o !== 2'b10) begin
      n_fail++;
      $display("FAIL burst_grant: got %b required 10", gnt_o);
    end
    drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_9999, 3'b000);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        cti = (k == 3) ? 3'b111 : 3'b010;
        drv(1'b1, 1'b1, 1'b1, 1'b1, AW'(4 + k), DW'(32'h100 + 4 + k), cti);
        push(1'b1, 1'b1, AW'(4 + k), DW'(32'h100 + 4 + k));
      end
      tick();
      slave_ack(32'h0);
      tick();
      s_ack_i = 1'b0;
    end
    settle();
    n_checks++;
    if ({state_out, gnt_o, m_ack_o} !== 6'b01_10_00) begin
      n_fail++;
      $display("FAIL burst_hold_after_eob: got state/gnt/ack %b required 011000",
               {state_out, gnt_o, m_ack_o});
    end
    drv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    tick();
    n_checks++;
    if (gnt_o !== 2'b00) begin
      n_fail++;
      $display("FAIL burst_release: got %b required 00", gnt_o);
    end
    tick();
    push(1'b0, 1'b1, 5'd9, 32'h0000_9999);
    n_checks++;
    if (gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL burst_next_owner: got %b required 01", gnt_o);
    end
    tick();
    slave_ack(32'h0);
    tick();
    s_ack_i = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    tick();
  endtask

  task automatic test_timeout();
    drv(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, '0, 3'b000);
    push(1'b0, 1'b0, 5'd3, '0);
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      n_checks++;
      if ({m_err_o, timeout_o, s_cyc_o} !== 4'b0001) begin
        n_fail++;
        $display("FAIL wd_early_%0d: got err/to/cyc %b required 0001", i,
                 {m_err_o, timeout_o, s_cyc_o});
      end
      tick();
    end
    slave_ack(32'hCAFE_F00D);
    n_checks++;
    if ({m_err_o, timeout_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL wd_ack_wins: got err/to %b required 000", {m_err_o, timeout_o});
    end
    tick();
    s_ack_i = 1'b0;
    drv(1'b0, 1'b1, 1'b1, 1'b0, 5'd20, '0, 3'b000);
    settle();
    n_checks++;
    if ({state_out, timeout_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL wd_after_ack: got state/to %b required 010", {state_out, timeout_o});
    end
    for (int i = 0; i < TO; i++) begin
      n_checks++;
      if ({m_err_o, timeout_o, s_cyc_o, s_addr_o} !== {4'b0001, 5'd20}) begin
        n_fail++;
        $display("FAIL wd_stall_%0d: got %b required %b", i,
                 {m_err_o, timeout_o, s_cyc_o, s_addr_o}, {4'b0001, 5'd20});
      end
      tick();
    end
    n_checks++;
    if ({state_out, m_err_o, timeout_o, s_cyc_o, s_stb_o} !== 7'b10_01_1_0_0) begin
      n_fail++;
      $display("FAIL wd_abort: got state/err/to/cyc/stb %b required 1001100",
               {state_out, m_err_o, timeout_o, s_cyc_o, s_stb_o});
    end
    $display("txn m0 addr=%h timeout err=%b timeout_o=%b", 5'd20, m_err_o, timeout_o);
    tick();
    s_ack_i = 1'b1;
    settle();
    n_checks++;
    if ({state_out, m_err_o, timeout_o, m_ack_o, s_cyc_o} !== 8'b10_00_0_00_0) begin
      n_fail++;
      $display("FAIL wd_abort_hold: got state/err/to/ack/cyc %b required 10000000",
               {state_out, m_err_o, timeout_o, m_ack_o, s_cyc_o});
    end
    s_ack_i = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    tick();
    n_checks++;
    if ({state_out, gnt_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL wd_to_idle: got state/gnt %b required 0000", {state_out, gnt_o});
    end
  endtask

  task automatic test_reset_mid_burst();
    drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_0808, 3'b010);
    push(1'b0, 1'b1, 5'd8, 32'h0000_0808);
    tick();
    tick();
    slave_ack(32'h0);
    tick();
    s_ack_i = 1'b0;
    drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0909, 3'b010);
    tick();
    s_ack_i = 1'b1;
    rst_ni  = 1'b0;
    settle();
    n_checks++;
    if ({state_out, gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o, s_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b required 0",
               {state_out, gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o, s_addr_o});
    end
    sb_q.delete();
    s_ack_i = 1'b0;
    drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd1, '0, 3'b000);
    tick();
    rst_ni = 1'b1;
    tick();
    n_checks++;
    if (gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_priority: got %b required 01", gnt_o);
    end
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_timeout();
    test_reset_mid_burst();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d queued required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
